// File: rtl/core_mc.sv
// core_mc: multi-cycle segmented core with req/ack instruction and data memory handshakes.
// Ports: clk/rst (async, active-high); imem_req/imem_addr/imem_ack/instruction fetch port;
//        dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack data port;
//        io_input/io_output memory-mapped I/O at the all-ones data address; halted status.
module core_mc #(
   parameter int DATA_W    = 8,
   parameter int NREG      = 16,
   parameter int IADDR_W   = 9,
   parameter int DADDR_W   = 10,
   parameter int SEG_SHIFT = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [IADDR_W-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [15:0]        instruction,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ack,
   input  logic [DATA_W-1:0]  io_input,
   output logic [DATA_W-1:0]  io_output,
   output logic               halted
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
   state_t state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [IADDR_W-1:0] ip_q, ip_d;
   logic [DATA_W-1:0] cs_q, cs_d, ds_q, ds_d, io_q, io_d;
   logic [3:0] flags_q, flags_d;
   logic skip_q, skip_d;
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic [3:0] op, ra, rb;
   logic [2:0] sub;
   logic [DATA_W-1:0] a, b, bb, alu_r, wd_a;
   logic [DATA_W:0] sum;
   logic [DADDR_W-1:0] daddr;
   logic is_load, is_store, is_mem, is_io, arith, is_sub, alu_c, alu_v, wr_a, wr_b;
   assign op = ir_q[15:12];
   assign ra = ir_q[11:8];
   assign rb = ir_q[7:4];
   assign sub = ir_q[2:0];
   // indices beyond the implemented register count read as zero
   assign a = (int'(ra) < NREG) ? regs_q[ra] : '0;
   assign b = (int'(rb) < NREG) ? regs_q[rb] : '0;
   assign is_load = op == 4'd2 || op == 4'd8;
   assign is_store = op == 4'd3 || op == 4'd9;
   assign is_mem = is_load || is_store;
   // widen before shifting so segment bits are kept up to the address width
   assign daddr = (op == 4'd2 || op == 4'd3) ? (DADDR_W'(ds_q) << SEG_SHIFT) + DADDR_W'(b) : DADDR_W'(ir_q[9:0]);
   assign is_io = daddr == '1;
   assign is_sub = sub == 3'd1 || sub == 3'd7;
   assign arith = sub == 3'd0 || is_sub;
   assign bb = is_sub ? ~b : b;
   assign sum = {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, is_sub};
   assign alu_r = arith ? sum[DATA_W-1:0] : sub == 3'd2 ? a & b : sub == 3'd3 ? a | b :
                  sub == 3'd4 ? a ^ b : sub == 3'd5 ? a << 1 : a >> 1;
   assign alu_c = arith ? sum[DATA_W] : sub == 3'd5 ? a[DATA_W-1] : sub == 3'd6 ? a[0] : 1'b0;
   // overflow: addends of equal sign producing a result of the other sign
   assign alu_v = arith && a[DATA_W-1] == bb[DATA_W-1] && alu_r[DATA_W-1] != a[DATA_W-1];
   always_comb begin
      state_d = state_q;
      ir_d = ir_q;
      ip_d = ip_q;
      cs_d = cs_q;
      ds_d = ds_q;
      io_d = io_q;
      flags_d = flags_q;
      skip_d = skip_q;
      regs_d = regs_q;
      wr_a = 1'b0;
      wr_b = 1'b0;
      wd_a = '0;
      case (state_q)
         FETCH: begin
            ir_d = imem_ack ? instruction : ir_q;
            state_d = imem_ack ? EXEC : FETCH;
         end
         EXEC: begin
            state_d = FETCH;
            ip_d = ip_q + 1'b1;
            if (skip_q)
               skip_d = 1'b0;
            else if (op == 4'd15) begin
               state_d = HALT;
               ip_d = ip_q;
            end else if (is_mem && !is_io) begin
               state_d = MEM;
               ip_d = ip_q;
            end else
               case (op)
                  4'd0: begin wr_a = 1'b1; wd_a = b; end
                  4'd1: begin wr_a = 1'b1; wd_a = b; wr_b = 1'b1; end
                  4'd2, 4'd8: begin wr_a = 1'b1; wd_a = io_input; end
                  4'd3, 4'd9: io_d = a;
                  4'd5: skip_d = (flags_q & ir_q[7:4]) == ir_q[3:0];
                  4'd6: begin
                     flags_d = {alu_v, alu_c, alu_r[DATA_W-1], alu_r == '0};
                     wr_a = sub != 3'd7;
                     wd_a = alu_r;
                  end
                  4'd7: begin wr_a = 1'b1; wd_a = DATA_W'(ir_q[7:0]); end
                  4'd10: ds_d = a;
                  4'd11: begin cs_d = a; ip_d = '0; end
                  default: ;
               endcase
         end
         MEM: begin
            state_d = dmem_ack ? FETCH : MEM;
            ip_d = dmem_ack ? ip_q + 1'b1 : ip_q;
            wr_a = dmem_ack && is_load;
            wd_a = dmem_rdata;
         end
         default: ;
      endcase
      if (wr_b && int'(rb) < NREG) regs_d[rb] = a;
      if (wr_a && int'(ra) < NREG) regs_d[ra] = wd_a;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         ir_q <= '0;
         ip_q <= '0;
         cs_q <= '0;
         ds_q <= '0;
         io_q <= '0;
         flags_q <= '0;
         skip_q <= 1'b0;
         regs_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         ir_q <= ir_d;
         ip_q <= ip_d;
         cs_q <= cs_d;
         ds_q <= ds_d;
         io_q <= io_d;
         flags_q <= flags_d;
         skip_q <= skip_d;
         regs_q <= regs_d;
      end
   end
   assign imem_req = state_q == FETCH && !rst;
   assign imem_addr = (IADDR_W'(cs_q) << SEG_SHIFT) + ip_q;
   assign dmem_req = state_q == MEM && !rst;
   assign dmem_we = is_store;
   assign dmem_addr = daddr;
   assign dmem_wdata = a;
   assign io_output = io_q;
   assign halted = state_q == HALT;
endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: random programs checked cycle by cycle against an instruction-level model of core_mc.
module tb_core_mc;
   localparam int DW = 8, NR = 12, IW = 9, AW = 10, SS = 2, M = 1 << DW;
   logic clk = 1'b0, rst = 1'b1;
   logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
   logic [IW-1:0] imem_addr;
   logic [15:0] instruction;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, dmem_rdata, io_input, io_output;
   always #5 clk = ~clk;
   core_mc #(.DATA_W(DW), .NREG(NR), .IADDR_W(IW), .DADDR_W(AW), .SEG_SHIFT(SS)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .instruction(instruction), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .io_input(io_input),
      .io_output(io_output), .halted(halted));
   int n_chk = 0, n_fail = 0;
   logic [15:0] imem [1 << IW];
   int dm [1 << AW];
   int mr [16];
   int m_ip, m_cs, m_ds, m_fl, m_skip, m_io, m_in;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic int rd(input int i);
      return i < NR ? mr[i] : 0;
   endfunction
   task automatic wr(input int i, input int v);
      if (i < NR) mr[i] = v % M;
   endtask
   function automatic int sgn(input int v);
      return v >= M / 2 ? v - M : v;
   endfunction
   task automatic model_step(input logic [15:0] w, output bit mem, output bit we, output int ma,
                             output int mwd, output int mrd, output bit hlt);
      int op = int'(w[15:12]), ra = int'(w[11:8]), rb = int'(w[7:4]), sb = int'(w[2:0]);
      int a = rd(ra), b = rd(rb), r = 0, s = 0, c = 0, v = 0, ss = 0;
      mem = 0; we = 0; ma = 0; mwd = a; mrd = 0; hlt = 0;
      if (m_skip != 0) begin
         m_skip = 0;
         m_ip = (m_ip + 1) % (1 << IW);
         return;
      end
      if (op == 15) begin
         hlt = 1;
         return;
      end
      if (op == 11) begin
         m_cs = a;
         m_ip = 0;
         return;
      end
      case (op)
         0: wr(ra, b);
         1: begin wr(ra, b); wr(rb, a); end
         2, 3, 8, 9: begin
            ma = (op < 8) ? (m_ds * (1 << SS) + b) % (1 << AW) : int'(w[9:0]) % (1 << AW);
            if (ma == (1 << AW) - 1) begin
               if (op == 2 || op == 8) wr(ra, m_in); else m_io = a;
            end else begin
               mem = 1;
               we = (op == 3 || op == 9);
               if (we) dm[ma] = a;
               else begin mrd = dm[ma]; wr(ra, mrd); end
            end
         end
         5: m_skip = ((m_fl & int'(w[7:4])) == int'(w[3:0])) ? 1 : 0;
         6: begin
            if (sb == 0) begin s = a + b; ss = sgn(a) + sgn(b); end
            if (sb == 1 || sb == 7) begin s = a + (M - 1 - b) + 1; ss = sgn(a) - sgn(b); end
            if (sb <= 1 || sb == 7) begin
               r = s % M; c = s >= M ? 1 : 0; v = (ss >= M / 2 || ss < -M / 2) ? 1 : 0;
            end
            if (sb == 2) r = a & b;
            if (sb == 3) r = a | b;
            if (sb == 4) r = a ^ b;
            if (sb == 5) begin r = (a * 2) % M; c = a >= M / 2 ? 1 : 0; end
            if (sb == 6) begin r = a / 2; c = a % 2; end
            m_fl = v * 8 + c * 4 + (r >= M / 2 ? 2 : 0) + (r == 0 ? 1 : 0);
            if (sb != 7) wr(ra, r);
         end
         7: wr(ra, int'(w[7:0]));
         10: m_ds = a;
         default: ;
      endcase
      m_ip = (m_ip + 1) % (1 << IW);
   endtask
   task automatic do_reset;
      #2 rst = 1'b1;
      #1 check("rst_imem_req", 32'(imem_req), 0);
      check("rst_dmem_req", 32'(dmem_req), 0);
      @(negedge clk);
      check("rst_halted", 32'(halted), 0);
      check("rst_io_output", 32'(io_output), 0);
      @(negedge clk);
      rst = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      for (int i = 0; i < 16; i++) mr[i] = 0;
      m_ip = 0; m_cs = 0; m_ds = 0; m_fl = 0; m_skip = 0; m_io = 0;
      #1;
   endtask
   task automatic run_instr(input int idl, input int ddl, output bit stop);
      int ia = (m_cs * (1 << SS) + m_ip) % (1 << IW);
      logic [15:0] w = imem[ia];
      bit mem, we, hlt;
      int ma, mwd, mrd;
      check("io_output", 32'(io_output), m_io);
      check("halted", 32'(halted), 0);
      check("fetch_dmem_req", 32'(dmem_req), 0);
      for (int i = 0; i <= idl; i++) begin
         if (i > 0) @(negedge clk);
         check("imem_req", 32'(imem_req), 1);
         check("imem_addr", 32'(imem_addr), ia);
         imem_ack = (i == idl);
         instruction = imem_ack ? w : 16'($urandom);
         dmem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      instruction = 16'($urandom);
      check("exec_imem_req", 32'(imem_req), 0);
      check("exec_dmem_req", 32'(dmem_req), 0);
      model_step(w, mem, we, ma, mwd, mrd, hlt);
      stop = hlt;
      if (hlt) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'b1;
            check("halt_halted", 32'(halted), 1);
            check("halt_imem_req", 32'(imem_req), 0);
            check("halt_dmem_req", 32'(dmem_req), 0);
         end
         return;
      end
      if (mem)
         for (int i = 0; i <= ddl; i++) begin
            @(negedge clk);
            check("dmem_req", 32'(dmem_req), 1);
            check("dmem_we", 32'(dmem_we), 32'(we));
            check("dmem_addr", 32'(dmem_addr), ma);
            if (we) check("dmem_wdata", 32'(dmem_wdata), mwd);
            check("mem_imem_req", 32'(imem_req), 0);
            dmem_ack = (i == ddl);
            dmem_rdata = dmem_ack ? DW'(mrd) : DW'($urandom);
            imem_ack = 1'($urandom_range(0, 1));
         end
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask
   initial begin
      bit stop;
      logic [15:0] w;
      logic [15:0] prog [20];
      prog = '{16'h7305, 16'h7403, 16'h6340, 16'h93FF, 16'h7100, 16'h7201, 16'h6121, 16'h5022,
               16'h7777, 16'h7355, 16'h93FF, 16'h7A01, 16'hAA00, 16'h7503, 16'h2650, 16'h3650,
               16'h83FF, 16'h93FF, 16'h7806, 16'hB800};
      imem_ack = 1'b0; dmem_ack = 1'b0; instruction = '0; dmem_rdata = '0; io_input = '0;
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < (1 << IW); i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'd15 && $urandom_range(0, 40) != 0) w[15:12] = 4'd7;
            if ((w[15:12] == 4'd8 || w[15:12] == 4'd9) && $urandom_range(0, 3) == 0) w[9:0] = 10'h3FF;
            imem[i] = w;
         end
         for (int i = 0; i < (1 << AW); i++) dm[i] = int'($urandom_range(0, M - 1));
         m_in = int'($urandom_range(0, M - 1));
         if (p == 0) begin
            for (int i = 0; i < 20; i++) imem[i] = prog[i];
            imem[24] = 16'hF000;
            m_in = 'h5A;
         end
         io_input = DW'(m_in);
         do_reset();
         stop = 0;
         for (int s = 0; s < 150 && !stop; s++)
            run_instr(p == 0 ? 0 : $urandom_range(0, 3), p == 0 ? 3 : $urandom_range(0, 3), stop);
         if (p == 0) begin
            check("directed_halt", 32'(stop), 1);
            check("directed_io", 32'(io_output), 'h5A);
         end
      end
      imem[0] = 16'h9005;
      do_reset();
      check("mr_imem_req", 32'(imem_req), 1);
      imem_ack = 1'b1;
      instruction = imem[0];
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      check("mr_dmem_req", 32'(dmem_req), 1);
      check("mr_dmem_addr", 32'(dmem_addr), 5);
      #2 rst = 1'b1;
      #1 check("mr_dmem_drop", 32'(dmem_req), 0);
      check("mr_imem_drop", 32'(imem_req), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("mr_restart_req", 32'(imem_req), 1);
      check("mr_restart_addr", 32'(imem_addr), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
